// File: rtl/counter_sched.sv
// Multi-channel one-shot/periodic timer scheduler with round-robin expiry events.
// Optional overrun detection is compiled in with COUNTER_SCHED_OVERRUN_EN.
`timescale 1ns/1ps
module counter_sched #(
  parameter  int WIDTH = 32,
  parameter  int NCH   = 4,
  localparam int CW    = $clog2(NCH)
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             ARM_VALID,
  output logic             ARM_READY,
  input  logic [CW-1:0]    ARM_CH,
  input  logic [WIDTH-1:0] ARM_DELAY,
  input  logic             ARM_PERIODIC,
  input  logic [NCH-1:0]   CANCEL,
  output logic             EVT_VALID,
  input  logic             EVT_READY,
  output logic [CW-1:0]    EVT_CH,
  output logic [WIDTH-1:0] EVT_TIME,
  output logic [NCH-1:0]   BUSY,
`ifdef COUNTER_SCHED_OVERRUN_EN
  output logic [NCH-1:0]   OVERRUN,
  input  logic [NCH-1:0]   OVERRUN_CLR,
`endif
  output logic [WIDTH-1:0] NOW
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_PENDING = 2'd2
  } ch_state_e;

  ch_state_e        state_q     [NCH];
  ch_state_e        state_d     [NCH];
  logic [WIDTH-1:0] deadline_q  [NCH];
  logic [WIDTH-1:0] deadline_d  [NCH];
  logic [WIDTH-1:0] period_q    [NCH];
  logic [WIDTH-1:0] period_d    [NCH];
  logic [WIDTH-1:0] pend_time_q [NCH];
  logic [WIDTH-1:0] pend_time_d [NCH];
  logic [NCH-1:0]   periodic_q, periodic_d;
  logic [NCH-1:0]   kill_q, kill_d;
  logic [WIDTH-1:0] now_q, now_d;
  logic [CW-1:0]    ptr_q, ptr_d;
  logic             evt_valid_q, evt_valid_d;
  logic [CW-1:0]    evt_ch_q, evt_ch_d;
  logic [WIDTH-1:0] evt_time_q, evt_time_d;

  logic [NCH-1:0]   presented, cand;
  logic [CW-1:0]    gnt_idx;
  logic             gnt_found, grant, hs, evt_free, arm_fire;
  logic [WIDTH-1:0] d_eff;
  int               rr_idx;

  // Handshake: a transfer happens on the cycle EVT_VALID && EVT_READY; the
  // event fields are held until then, and a new grant may load on that edge.
  always_comb begin
    hs        = evt_valid_q & EVT_READY;
    evt_free  = ~evt_valid_q | EVT_READY;
    presented = '0;
    cand      = '0;
    ARM_READY = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      presented[i] = evt_valid_q && (evt_ch_q == CW'(i));
      // A channel being cancelled is never granted, so it cannot be both loaded and dropped.
      cand[i]      = (state_q[i] == ST_PENDING) && !presented[i] && !CANCEL[i];
      if ((ARM_CH == CW'(i)) && (state_q[i] == ST_IDLE)) ARM_READY = 1'b1;
    end
    gnt_found = 1'b0;
    gnt_idx   = '0;
    rr_idx    = 0;
    for (int k = 0; k < NCH; k++) begin
      rr_idx = (int'(ptr_q) + k) % NCH;
      if (!gnt_found && cand[rr_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = CW'(rr_idx);
      end
    end
    grant    = gnt_found & evt_free;
    arm_fire = ARM_VALID & ARM_READY;
    d_eff    = (ARM_DELAY == '0) ? WIDTH'(1) : ARM_DELAY;
  end

  always_comb begin
    now_d       = now_q + WIDTH'(1);
    ptr_d       = ptr_q;
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_time_d  = evt_time_q;
    if (grant) begin
      evt_valid_d = 1'b1;
      evt_ch_d    = gnt_idx;
      evt_time_d  = pend_time_q[gnt_idx];
      ptr_d       = (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + CW'(1);
    end else if (hs) begin
      evt_valid_d = 1'b0;
    end
  end

  always_comb begin
    periodic_d = periodic_q;
    kill_d     = kill_q;
    for (int i = 0; i < NCH; i++) begin
      state_d[i]     = state_q[i];
      deadline_d[i]  = deadline_q[i];
      period_d[i]    = period_q[i];
      pend_time_d[i] = pend_time_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (arm_fire && (ARM_CH == CW'(i))) begin
            state_d[i]    = ST_ARMED;
            deadline_d[i] = now_q + d_eff;
            period_d[i]   = d_eff;
            periodic_d[i] = ARM_PERIODIC;
            kill_d[i]     = 1'b0;
          end
        end
        ST_ARMED: begin
          if (CANCEL[i]) begin
            state_d[i] = ST_IDLE;
          end else if (now_q == deadline_q[i]) begin
            state_d[i]     = ST_PENDING;
            pend_time_d[i] = now_q;
          end
        end
        ST_PENDING: begin
          if (presented[i]) begin
            // The presented event always completes; a cancel only stops the reload.
            if (hs) begin
              kill_d[i] = 1'b0;
              if (periodic_q[i] && !kill_q[i] && !CANCEL[i]) begin
                state_d[i]    = ST_ARMED;
                deadline_d[i] = now_q + period_q[i];
              end else begin
                state_d[i] = ST_IDLE;
              end
            end else if (CANCEL[i]) begin
              kill_d[i] = 1'b1;
            end
          end else if (CANCEL[i]) begin
            state_d[i] = ST_IDLE;
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      now_q       <= '0;
      ptr_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_time_q  <= '0;
      periodic_q  <= '0;
      kill_q      <= '0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i]     <= ST_IDLE;
        deadline_q[i]  <= '0;
        period_q[i]    <= '0;
        pend_time_q[i] <= '0;
      end
    end else begin
      now_q       <= now_d;
      ptr_q       <= ptr_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_time_q  <= evt_time_d;
      periodic_q  <= periodic_d;
      kill_q      <= kill_d;
      for (int i = 0; i < NCH; i++) begin
        state_q[i]     <= state_d[i];
        deadline_q[i]  <= deadline_d[i];
        period_q[i]    <= period_d[i];
        pend_time_q[i] <= pend_time_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) BUSY[i] = (state_q[i] != ST_IDLE);
  end

  assign NOW       = now_q;
  assign EVT_VALID = evt_valid_q;
  assign EVT_CH    = evt_ch_q;
  assign EVT_TIME  = evt_time_q;

`ifdef COUNTER_SCHED_OVERRUN_EN
  logic [WIDTH-1:0] age_q [NCH];
  logic [WIDTH-1:0] age_d [NCH];
  logic [NCH-1:0]   overrun_q, overrun_d;

  // age counts completed cycles spent PENDING (waiting or presented).
  always_comb begin
    overrun_d = overrun_q & ~OVERRUN_CLR;
    for (int i = 0; i < NCH; i++) begin
      age_d[i] = '0;
      if (state_q[i] == ST_PENDING) begin
        age_d[i] = (age_q[i] == '1) ? age_q[i] : age_q[i] + WIDTH'(1);
        if (periodic_q[i] && (age_q[i] >= period_q[i] - WIDTH'(1))) overrun_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      overrun_q <= '0;
      for (int i = 0; i < NCH; i++) age_q[i] <= '0;
    end else begin
      overrun_q <= overrun_d;
      for (int i = 0; i < NCH; i++) age_q[i] <= age_d[i];
    end
  end

  assign OVERRUN = overrun_q;
`endif

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched (WIDTH=8 so the timebase wraps quickly).
// Exercises the overrun ports too when COUNTER_SCHED_OVERRUN_EN is defined.
`timescale 1ns/1ps
module tb_counter_sched;
  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int CW    = 2;

  logic             CLK, RSTN;
  logic             ARM_VALID, ARM_READY, ARM_PERIODIC;
  logic [CW-1:0]    ARM_CH;
  logic [WIDTH-1:0] ARM_DELAY;
  logic [NCH-1:0]   CANCEL, BUSY;
  logic             EVT_VALID, EVT_READY;
  logic [CW-1:0]    EVT_CH;
  logic [WIDTH-1:0] EVT_TIME, NOW;
`ifdef COUNTER_SCHED_OVERRUN_EN
  logic [NCH-1:0]   OVERRUN, OVERRUN_CLR;
`endif

  int checks = 0;
  int errors = 0;

  counter_sched #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .ARM_VALID(ARM_VALID), .ARM_READY(ARM_READY), .ARM_CH(ARM_CH),
    .ARM_DELAY(ARM_DELAY), .ARM_PERIODIC(ARM_PERIODIC), .CANCEL(CANCEL),
    .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_CH(EVT_CH),
    .EVT_TIME(EVT_TIME), .BUSY(BUSY),
`ifdef COUNTER_SCHED_OVERRUN_EN
    .OVERRUN(OVERRUN), .OVERRUN_CLR(OVERRUN_CLR),
`endif
    .NOW(NOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_now(input logic [WIDTH-1:0] t);
    int n;
    n = 0;
    while (NOW !== t && n < 600) begin
      step();
      n++;
    end
    chk("wait_now", 32'(NOW), 32'(t));
  endtask

  task automatic arm_cycle(input int ch, input int d, input logic per);
    ARM_VALID    = 1'b1;
    ARM_CH       = CW'(ch);
    ARM_DELAY    = WIDTH'(d);
    ARM_PERIODIC = per;
    step();
    ARM_VALID    = 1'b0;
  endtask

  initial begin
    int saw;
    RSTN = 1'b0; ARM_VALID = 1'b0; ARM_CH = '0; ARM_DELAY = '0; ARM_PERIODIC = 1'b0;
    CANCEL = '0; EVT_READY = 1'b1;
`ifdef COUNTER_SCHED_OVERRUN_EN
    OVERRUN_CLR = '0;
`endif
    #1;
    chk("rst_now", 32'(NOW), 0);
    chk("rst_evt_valid", 32'(EVT_VALID), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_arm_ready", 32'(ARM_READY), 1);
    @(negedge CLK);
    RSTN = 1'b1;
    step();
    chk("now_first", 32'(NOW), 1);

    // One-shot ch0, D=5 at NOW=10: pending after 15, event in the NOW=17 cycle.
    wait_now(10);
    chk("t1_arm_ready", 32'(ARM_READY), 1);
    arm_cycle(0, 5, 1'b0);
    chk("t1_busy", 32'(BUSY), 32'b0001);
    wait_now(16);
    chk("t1_no_evt_16", 32'(EVT_VALID), 0);
    step();
    chk("t1_evt_valid", 32'(EVT_VALID), 1);
    chk("t1_evt_ch", 32'(EVT_CH), 0);
    chk("t1_evt_time", 32'(EVT_TIME), 15);
    step();
    chk("t1_evt_done", 32'(EVT_VALID), 0);
    chk("t1_busy_clr", 32'(BUSY), 0);

    // Three channels on deadline 30: back-to-back events 1,2,3.
    wait_now(20);
    arm_cycle(1, 10, 1'b0);
    arm_cycle(2, 9, 1'b0);
    arm_cycle(3, 8, 1'b0);
    wait_now(31);
    chk("t2_no_evt_31", 32'(EVT_VALID), 0);
    chk("t2_busy", 32'(BUSY), 32'b1110);
    step();
    chk("t2_e1_ch", 32'(EVT_CH), 1);
    chk("t2_e1_time", 32'(EVT_TIME), 30);
    step();
    chk("t2_e2_valid", 32'(EVT_VALID), 1);
    chk("t2_e2_ch", 32'(EVT_CH), 2);
    step();
    chk("t2_e3_ch", 32'(EVT_CH), 3);
    chk("t2_e3_time", 32'(EVT_TIME), 30);
    step();
    chk("t2_done", 32'(EVT_VALID), 0);
    chk("t2_busy_clr", 32'(BUSY), 0);

    // Last grant ch1, then 0,2,3 on one deadline: order 2,3,0.
    wait_now(40);
    arm_cycle(1, 5, 1'b0);
    wait_now(47);
    chk("t2r_single_ch", 32'(EVT_CH), 1);
    wait_now(50);
    arm_cycle(0, 10, 1'b0);
    arm_cycle(2, 9, 1'b0);
    arm_cycle(3, 8, 1'b0);
    wait_now(62);
    chk("t2r_e1_valid", 32'(EVT_VALID), 1);
    chk("t2r_e1_ch", 32'(EVT_CH), 2);
    step();
    chk("t2r_e2_ch", 32'(EVT_CH), 3);
    step();
    chk("t2r_e3_ch", 32'(EVT_CH), 0);
    chk("t2r_e3_time", 32'(EVT_TIME), 60);
    step();
    chk("t2r_done", 32'(EVT_VALID), 0);

    // Wrapping deadline: D=4 at NOW=254 -> deadline 2.
    wait_now(254);
    arm_cycle(2, 4, 1'b0);
    step();
    chk("t3_now_wrap", 32'(NOW), 0);
    wait_now(3);
    chk("t3_no_evt_3", 32'(EVT_VALID), 0);
    step();
    chk("t3_evt_valid", 32'(EVT_VALID), 1);
    chk("t3_evt_ch", 32'(EVT_CH), 2);
    chk("t3_evt_time", 32'(EVT_TIME), 2);
    step();
    chk("t3_done", 32'(EVT_VALID), 0);

    // Periodic ch1 D=8, stalled 3 cycles, reload from handshake NOW, then cancel.
    wait_now(10);
    EVT_READY = 1'b0;
    arm_cycle(1, 8, 1'b1);
    wait_now(19);
    chk("t4_no_evt_19", 32'(EVT_VALID), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_stall_valid", 32'(EVT_VALID), 1);
      chk("t4_stall_ch", 32'(EVT_CH), 1);
      chk("t4_stall_time", 32'(EVT_TIME), 18);
    end
    step();
    EVT_READY = 1'b1;
    chk("t4_hs_time", 32'(EVT_TIME), 18);
    step();
    chk("t4_after_hs", 32'(EVT_VALID), 0);
    chk("t4_rearmed_busy", 32'(BUSY), 32'b0010);
    wait_now(32);
    chk("t4_no_evt_32", 32'(EVT_VALID), 0);
    step();
    chk("t4_e2_valid", 32'(EVT_VALID), 1);
    chk("t4_e2_time", 32'(EVT_TIME), 31);
    step();
    step();
    CANCEL = 4'b0010;
    step();
    CANCEL = '0;
    chk("t4_cancel_busy", 32'(BUSY), 0);
    saw = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (EVT_VALID) saw = 1;
    end
    chk("t4_no_evt_after_cancel", 32'(saw), 0);

    // Cancel while presented: event completes, periodic channel then goes idle.
    wait_now(50);
    EVT_READY = 1'b0;
    arm_cycle(3, 3, 1'b1);
    wait_now(55);
    chk("t4c_valid", 32'(EVT_VALID), 1);
    chk("t4c_time", 32'(EVT_TIME), 53);
    CANCEL = 4'b1000;
    step();
    CANCEL = '0;
    chk("t4c_still_valid", 32'(EVT_VALID), 1);
    chk("t4c_still_busy", 32'(BUSY), 32'b1000);
    EVT_READY = 1'b1;
    step();
    chk("t4c_done", 32'(EVT_VALID), 0);
    chk("t4c_idle", 32'(BUSY), 0);

    // Arm on a busy channel is refused and leaves the deadline untouched.
    wait_now(60);
    arm_cycle(0, 20, 1'b0);
    ARM_VALID = 1'b1; ARM_CH = 2'd0; ARM_DELAY = 8'd2; ARM_PERIODIC = 1'b0;
    chk("t5_arm_ready_busy", 32'(ARM_READY), 0);
    step();
    ARM_VALID = 1'b0;
    chk("t5_busy", 32'(BUSY), 32'b0001);
    wait_now(66);
    chk("t5_no_early_evt", 32'(EVT_VALID), 0);
    EVT_READY = 1'b0;
    wait_now(82);
    chk("t5_evt_valid", 32'(EVT_VALID), 1);
    chk("t5_evt_time", 32'(EVT_TIME), 80);
    step();
    chk("t5_stalled", 32'(EVT_VALID), 1);

    // Reset mid-event drops it immediately; arm during reset is ignored.
    RSTN = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(EVT_VALID), 0);
    chk("t5_rst_now", 32'(NOW), 0);
    chk("t5_rst_busy", 32'(BUSY), 0);
    chk("t5_rst_time", 32'(EVT_TIME), 0);
    ARM_VALID = 1'b1; ARM_CH = 2'd1; ARM_DELAY = 8'd5; CANCEL = 4'b1111;
    step();
    chk("t5_rst_arm_ignored", 32'(BUSY), 0);
    chk("t5_rst_now_held", 32'(NOW), 0);
    ARM_VALID = 1'b0; CANCEL = '0; EVT_READY = 1'b1;
    @(negedge CLK);
    RSTN = 1'b1;
    step();
    chk("t5_now_restart", 32'(NOW), 1);

    // Arm and cancel together: arm wins. D=0 behaves as D=1.
    wait_now(3);
    ARM_VALID = 1'b1; ARM_CH = 2'd2; ARM_DELAY = 8'd3; ARM_PERIODIC = 1'b0; CANCEL = 4'b0100;
    step();
    ARM_VALID = 1'b0; CANCEL = '0;
    chk("t6_arm_wins", 32'(BUSY), 32'b0100);
    arm_cycle(1, 0, 1'b0);
    wait_now(7);
    chk("t6_d0_valid", 32'(EVT_VALID), 1);
    chk("t6_d0_ch", 32'(EVT_CH), 1);
    chk("t6_d0_time", 32'(EVT_TIME), 5);
    step();
    chk("t6_ch2_ch", 32'(EVT_CH), 2);
    chk("t6_ch2_time", 32'(EVT_TIME), 6);
    step();
    chk("t6_done", 32'(EVT_VALID), 0);
    chk("t6_idle", 32'(BUSY), 0);

`ifdef COUNTER_SCHED_OVERRUN_EN
    // Periodic D=4 with consumer stalled 6 cycles: sticky overrun until cleared.
    wait_now(10);
    EVT_READY = 1'b0;
    arm_cycle(2, 4, 1'b1);
    wait_now(18);
    chk("ov_not_yet", 32'(OVERRUN), 0);
    step();
    chk("ov_set", 32'(OVERRUN), 32'b0100);
    chk("ov_evt_time", 32'(EVT_TIME), 14);
    wait_now(22);
    EVT_READY = 1'b1;
    step();
    chk("ov_after_hs_valid", 32'(EVT_VALID), 0);
    chk("ov_sticky", 32'(OVERRUN), 32'b0100);
    CANCEL = 4'b0100;
    step();
    CANCEL = '0;
    chk("ov_cancel_busy", 32'(BUSY), 0);
    chk("ov_still_sticky", 32'(OVERRUN), 32'b0100);
    OVERRUN_CLR = 4'b0100;
    step();
    OVERRUN_CLR = '0;
    chk("ov_cleared", 32'(OVERRUN), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
